// File: rtl/qpi_flash_pkg.sv
// qpi_flash_pkg: opcode constants and shared enums for the QPI flash responder.
// Holds the transaction FSM state type and the command type latched at the
// opcode byte.
package qpi_flash_pkg;

  localparam logic [7:0] OpWren       = 8'h06;
  localparam logic [7:0] OpChipErase  = 8'h60;
  localparam logic [7:0] OpBlockErase = 8'hDC;
  localparam logic [7:0] OpProgram    = 8'h12;
  localparam logic [7:0] OpRead       = 8'hEC;
  localparam logic [7:0] OpReadSr1    = 8'h05;

  typedef enum logic [3:0] {
    StIdle,
    StOpcode,
    StAddr,
    StMode,
    StDummy,
    StReadData,
    StProgData,
    StSrOut,
    StIgnore
  } qpi_state_e;

  // Command that owns the address phase.
  typedef enum logic [1:0] {
    CmdNone,
    CmdRead,
    CmdProgram,
    CmdBlockErase
  } qpi_cmd_e;

endpackage

// File: rtl/qpi_sync_edge.sv
// qpi_sync_edge: 2-flop synchronizer plus edge detector on the synchronized copy.
// Ports:
//   clk, nReset : system clock, asynchronous active-low reset
//   i_d         : asynchronous input (WIDTH bits)
//   o_q         : synchronized level
//   o_rise      : one-clk pulse per bit on a synchronized 0->1
//   o_fall      : one-clk pulse per bit on a synchronized 1->0
module qpi_sync_edge #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/qpi_flash_responder.sv
// qpi_flash_responder: QPI serial-flash target backed by a byte-wide memory.
// Supports WREN (06), READ_SR1 (05), READ (EC, 4-byte addr + mode + dummy),
// PROGRAM (12, page wrap), BLOCK_ERASE (DC, 64 KiB) and CHIP_ERASE (60).
// Ports:
//   clk, nReset          : system clock (>= 4x f_sck), async active-low reset
//   f_sck, f_ncs         : QPI clock / chip select (async to clk)
//   f_io_in              : QPI nibble bus from the pad
//   f_io_out, f_io_oe    : QPI nibble bus to the pad and its output enable
//   mem_addr, mem_wdata  : backing memory byte address / write data
//   mem_we, mem_re       : backing memory strobes (read data valid next clk)
//   mem_rdata            : backing memory read data
//   wip                  : write-in-progress (SR1[0])
// Assumes ADDR_W <= 32.
module qpi_flash_responder
  import qpi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned DUMMY_NIBBLES = 6
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              f_sck,
  input  logic              f_ncs,
  input  logic [3:0]        f_io_in,
  output logic [3:0]        f_io_out,
  output logic              f_io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              wip
);

  localparam logic [ADDR_W-1:0] PageMask  = ADDR_W'(32'h0000_00FF);
  localparam logic [ADDR_W-1:0] BlockMask = ADDR_W'(32'h0000_FFFF);
  localparam logic [7:0]        DummyLast = 8'(DUMMY_NIBBLES - 1);

  // Synchronized bus
  logic       w_sck_q, w_sck_rise, w_sck_fall;
  logic       w_ncs, w_ncs_rise, w_ncs_fall;
  logic [3:0] w_io, w_io_rise, w_io_fall;

  qpi_sync_edge #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_sck (
    .clk    (clk),
    .nReset (nReset),
    .i_d    (f_sck),
    .o_q    (w_sck_q),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  qpi_sync_edge #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_ncs (
    .clk    (clk),
    .nReset (nReset),
    .i_d    (f_ncs),
    .o_q    (w_ncs),
    .o_rise (w_ncs_rise),
    .o_fall (w_ncs_fall)
  );

  qpi_sync_edge #(.WIDTH(4), .RST_VAL(4'h0)) u_sync_io (
    .clk    (clk),
    .nReset (nReset),
    .i_d    (f_io_in),
    .o_q    (w_io),
    .o_rise (w_io_rise),
    .o_fall (w_io_fall)
  );

  // State
  qpi_state_e        r_state, w_state_d, w_op_state;
  qpi_cmd_e          r_cmd, w_op_cmd;
  logic              r_nib_lo;
  logic [3:0]        r_hi_nib;
  logic [23:0]       r_addr_sh;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_dummy_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wel, r_wip;
  logic [4:0]        r_hold_cnt;
  logic              r_prog_pend, r_ers_pend, r_ers_busy;
  logic [ADDR_W-1:0] r_ers_first, r_ers_last, r_ers_addr;
  logic              r_tx_hi;
  logic [3:0]        r_tx_lo, r_io_out;
  logic              r_rd_vld;
  logic [7:0]        r_rd_buf;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we, r_mem_re;

  logic              w_nib_rise, w_byte_vld;
  logic [7:0]        w_byte, w_sr1, w_tx_byte;
  logic [31:0]       w_addr_full;
  logic [ADDR_W-1:0] w_new_addr, w_page_next;
  logic              w_unused;

  assign w_nib_rise  = w_sck_rise & ~w_ncs & (r_state != StIdle);
  assign w_byte_vld  = w_nib_rise & r_nib_lo;
  assign w_byte      = {r_hi_nib, w_io};
  assign w_sr1       = {6'b0, r_wel, r_wip};
  assign w_tx_byte   = (r_state == StSrOut) ? w_sr1 : r_rd_buf;
  assign w_addr_full = {r_addr_sh, w_byte};
  assign w_new_addr  = w_addr_full[ADDR_W-1:0];
  // Program address advances within the 256-byte page only.
  assign w_page_next = (r_addr & ~PageMask) | ((r_addr + ADDR_W'(1)) & PageMask);

  assign w_unused = ^{w_sck_q, w_ncs_fall, w_io_rise, w_io_fall, w_addr_full};

  // Opcode decode. While busy only READ_SR1 is honoured.
  always_comb begin
    w_op_state = StIgnore;
    w_op_cmd   = CmdNone;
    if (r_wip) begin
      if (w_byte == OpReadSr1) w_op_state = StSrOut;
    end else begin
      case (w_byte)
        OpReadSr1: w_op_state = StSrOut;
        OpRead: begin
          w_op_state = StAddr;
          w_op_cmd   = CmdRead;
        end
        OpProgram: begin
          if (r_wel) begin
            w_op_state = StAddr;
            w_op_cmd   = CmdProgram;
          end
        end
        OpBlockErase: begin
          if (r_wel) begin
            w_op_state = StAddr;
            w_op_cmd   = CmdBlockErase;
          end
        end
        default: w_op_state = StIgnore;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    if (w_ncs) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:   w_state_d = StOpcode;
        StOpcode: if (w_byte_vld) w_state_d = w_op_state;
        StAddr: begin
          if (w_byte_vld && (r_byte_cnt == 2'd3)) begin
            case (r_cmd)
              CmdRead:    w_state_d = StMode;
              CmdProgram: w_state_d = StProgData;
              default:    w_state_d = StIgnore;
            endcase
          end
        end
        StMode: begin
          if (w_byte_vld) w_state_d = (DUMMY_NIBBLES == 0) ? StReadData : StDummy;
        end
        StDummy: if (w_nib_rise && (r_dummy_cnt == DummyLast)) w_state_d = StReadData;
        default: w_state_d = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cmd       <= CmdNone;
      r_nib_lo    <= 1'b0;
      r_hi_nib    <= 4'h0;
      r_addr_sh   <= 24'h0;
      r_byte_cnt  <= 2'd0;
      r_dummy_cnt <= 8'd0;
      r_addr      <= '0;
      r_wel       <= 1'b0;
      r_wip       <= 1'b0;
      r_hold_cnt  <= 5'd0;
      r_prog_pend <= 1'b0;
      r_ers_pend  <= 1'b0;
      r_ers_busy  <= 1'b0;
      r_ers_first <= '0;
      r_ers_last  <= '0;
      r_ers_addr  <= '0;
      r_tx_hi     <= 1'b1;
      r_tx_lo     <= 4'h0;
      r_io_out    <= 4'h0;
      r_rd_vld    <= 1'b0;
      r_rd_buf    <= 8'h00;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_rd_vld <= r_mem_re;
      if (r_rd_vld) r_rd_buf <= mem_rdata;

      // Nibble assembly: high nibble first.
      if (r_state == StIdle) begin
        r_nib_lo <= 1'b0;
      end else if (w_nib_rise) begin
        r_nib_lo <= ~r_nib_lo;
        if (!r_nib_lo) r_hi_nib <= w_io;
      end

      case (r_state)
        StIdle: begin
          r_cmd       <= CmdNone;
          r_byte_cnt  <= 2'd0;
          r_dummy_cnt <= 8'd0;
          r_tx_hi     <= 1'b1;
          r_io_out    <= 4'h0;
        end
        StOpcode: begin
          if (w_byte_vld) begin
            r_cmd <= w_op_cmd;
            if (w_op_cmd == CmdProgram) r_prog_pend <= 1'b1;
            if (!r_wip && (w_byte == OpWren)) r_wel <= 1'b1;
            if (!r_wip && r_wel && (w_byte == OpChipErase)) begin
              r_ers_pend  <= 1'b1;
              r_ers_first <= '0;
              r_ers_last  <= '1;
            end
          end
        end
        StAddr: begin
          if (w_byte_vld) begin
            r_addr_sh  <= w_addr_full[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_addr <= w_new_addr;
              case (r_cmd)
                CmdRead: begin
                  // Prefetch the first byte during mode/dummy.
                  r_mem_re   <= 1'b1;
                  r_mem_addr <= w_new_addr;
                end
                CmdBlockErase: begin
                  r_ers_pend  <= 1'b1;
                  r_ers_first <= w_new_addr & ~BlockMask;
                  r_ers_last  <= w_new_addr | BlockMask;
                end
                default: ;
              endcase
            end
          end
        end
        StDummy: if (w_nib_rise) r_dummy_cnt <= r_dummy_cnt + 8'd1;
        StProgData: begin
          if (w_byte_vld) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_byte;
            r_addr      <= w_page_next;
          end
        end
        StReadData, StSrOut: begin
          if (w_sck_fall) begin
            if (r_tx_hi) begin
              // SR1 is re-sampled here, once per byte.
              r_io_out <= w_tx_byte[7:4];
              r_tx_lo  <= w_tx_byte[3:0];
              r_tx_hi  <= 1'b0;
              if (r_state == StReadData) begin
                r_mem_re   <= 1'b1;
                r_mem_addr <= r_addr + ADDR_W'(1);
                r_addr     <= r_addr + ADDR_W'(1);
              end
            end else begin
              r_io_out <= r_tx_lo;
              r_tx_hi  <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // End of transaction: commit program / launch erase.
      if (w_ncs_rise) begin
        r_prog_pend <= 1'b0;
        r_ers_pend  <= 1'b0;
        if (r_prog_pend) begin
          r_wel      <= 1'b0;
          r_wip      <= 1'b1;
          r_hold_cnt <= 5'd16;
        end
        if (r_ers_pend) begin
          r_ers_busy <= 1'b1;
          r_wip      <= 1'b1;
          r_ers_addr <= r_ers_first;
        end
      end

      if (r_hold_cnt != 5'd0) begin
        r_hold_cnt <= r_hold_cnt - 5'd1;
        if (r_hold_cnt == 5'd1) r_wip <= 1'b0;
      end

      // Erase walk runs independent of the bus; WIP blocks any memory command.
      if (r_ers_busy) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_ers_addr;
        r_mem_wdata <= 8'hFF;
        if (r_ers_addr == r_ers_last) begin
          r_ers_busy <= 1'b0;
          r_wip      <= 1'b0;
          r_wel      <= 1'b0;
        end else begin
          r_ers_addr <= r_ers_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign f_io_out  = r_io_out;
  assign f_io_oe   = (r_state == StReadData) || (r_state == StSrOut);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re & ~r_mem_we;
  assign wip       = r_wip;

endmodule

// File: tb/tb_qpi_flash_responder.sv
// Directed bench for qpi_flash_responder with a behavioural byte memory.
module tb_qpi_flash_responder;

  localparam int AW   = 18;
  localparam int HALF = 80;

  logic          clk = 1'b0;
  logic          nReset;
  logic          f_sck, f_ncs;
  logic [3:0]    f_io_in, f_io_out;
  logic          f_io_oe;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_we, mem_re, wip;

  logic [7:0]    mem_model [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  // Memory monitor state
  logic mon_en = 1'b0;
  int   we_cnt, bad_data, seq_bad, both_cnt;
  int   ers_exp, last_addr;

  always #5 clk = ~clk;

  qpi_flash_responder #(.ADDR_W(AW), .DUMMY_NIBBLES(6)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .f_sck     (f_sck),
    .f_ncs     (f_ncs),
    .f_io_in   (f_io_in),
    .f_io_out  (f_io_out),
    .f_io_oe   (f_io_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .wip       (wip)
  );

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we && mem_re) both_cnt++;
    if (mon_en && mem_we) begin
      we_cnt++;
      if (mem_wdata !== 8'hFF) bad_data++;
      if (int'(mem_addr) != ers_exp) seq_bad++;
      ers_exp   = ers_exp + 1;
      last_addr = int'(mem_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    f_io_in = n;
    #(HALF);
    f_sck = 1'b1;
    #(HALF);
    f_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic oe);
    oe = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #(HALF);
      b = {b[3:0], f_io_out};
      oe = oe & f_io_oe;
      f_sck = 1'b1;
      #(HALF);
      f_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    f_ncs = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    f_ncs = 1'b1;
    #(400);
  endtask

  task automatic wren();
    cs_begin();
    send_byte(8'h06);
    cs_end();
  endtask

  task automatic read_sr(output logic [7:0] v);
    logic oe;
    cs_begin();
    send_byte(8'h05);
    recv_byte(v, oe);
    cs_end();
  endtask

  task automatic wait_wip(input logic lvl, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wip === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    logic       oe, ok;
    int         cnt;

    f_sck = 1'b0; f_ncs = 1'b1; f_io_in = 4'h0; nReset = 1'b0;
    we_cnt = 0; bad_data = 0; seq_bad = 0; both_cnt = 0; ers_exp = 0; last_addr = 0;
    for (int i = 0; i < (1 << AW); i++) mem_model[i] = 8'h00;

    #25;
    check_eq("rst_oe",        32'(f_io_oe),   0);
    check_eq("rst_io_out",    32'(f_io_out),  0);
    check_eq("rst_mem_we_re", {30'd0, mem_we, mem_re}, 0);
    check_eq("rst_mem_addr",  32'(mem_addr),  0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
    check_eq("rst_wip",       32'(wip),       0);
    #20 nReset = 1'b1;
    repeat (5) @(negedge clk);

    // READ_SR1 on an idle device, repeated bytes
    cs_begin();
    send_byte(8'h05);
    recv_byte(rb, oe);
    check_eq("sr_idle", 32'(rb), 32'h00);
    check_eq("sr_oe", 32'(oe), 1);
    recv_byte(rb, oe);
    check_eq("sr_idle_repeat", 32'(rb), 32'h00);
    cs_end();
    check_eq("sr_oe_after", 32'(f_io_oe), 0);

    wren();
    read_sr(rb);
    check_eq("sr_after_wren", 32'(rb), 32'h02);

    // PROGRAM 0x001200: A5 5A, then 16 clk of WIP
    cs_begin();
    send_byte(8'h12);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h5A);
    #(HALF);
    f_ncs = 1'b1;
    wait_wip(1'b1, 20, ok);
    check_eq("prog_wip_rise", 32'(ok), 1);
    cnt = 0;
    while (wip === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("prog_wip_len", 32'(cnt), 16);
    check_eq("prog_mem_1200", 32'(mem_model[18'h01200]), 32'hA5);
    check_eq("prog_mem_1201", 32'(mem_model[18'h01201]), 32'h5A);
    #(400);
    read_sr(rb);
    check_eq("sr_after_prog", 32'(rb), 32'h00);

    // PROGRAM page wrap at 0x0023FF
    wren();
    cs_begin();
    send_byte(8'h12);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h23); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22);
    cs_end();
    check_eq("wrap_mem_23ff", 32'(mem_model[18'h023FF]), 32'h11);
    check_eq("wrap_mem_2300", 32'(mem_model[18'h02300]), 32'h22);
    check_eq("wrap_mem_2400", 32'(mem_model[18'h02400]), 32'h00);

    // READ 0x001200, mode 00, 6 dummy nibbles
    cs_begin();
    send_byte(8'hEC);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h00);
    send_byte(8'h00);
    #(HALF / 2);
    check_eq("read_oe_dummy", 32'(f_io_oe), 0);
    for (int i = 0; i < 6; i++) send_nib(4'h0);
    recv_byte(rb, oe);
    check_eq("read_byte0", 32'(rb), 32'hA5);
    check_eq("read_oe_data", 32'(oe), 1);
    recv_byte(rb, oe);
    check_eq("read_byte1", 32'(rb), 32'h5A);
    recv_byte(rb, oe);
    check_eq("read_byte2", 32'(rb), 32'h00);
    cs_end();
    check_eq("read_oe_after", 32'(f_io_oe), 0);

    // BLOCK_ERASE at 0x012300, with a PROGRAM and SR read mid-walk
    wren();
    we_cnt = 0; bad_data = 0; seq_bad = 0; ers_exp = 32'h10000;
    mon_en = 1'b1;
    cs_begin();
    send_byte(8'hDC);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h23); send_byte(8'h00);
    #(HALF);
    f_ncs = 1'b1;
    wait_wip(1'b1, 20, ok);
    check_eq("erase_wip_rise", 32'(ok), 1);
    repeat (100) @(negedge clk);
    cs_begin();
    send_byte(8'h12);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hAB);
    cs_end();
    read_sr(rb);
    check_eq("sr_mid_erase", 32'(rb), 32'h03);
    wait_wip(1'b0, 70000, ok);
    check_eq("erase_done", 32'(ok), 1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check_eq("erase_we_count", 32'(we_cnt), 65536);
    check_eq("erase_bad_data", 32'(bad_data), 0);
    check_eq("erase_seq", 32'(seq_bad), 0);
    check_eq("erase_last", 32'(last_addr), 32'h1FFFF);
    check_eq("erase_mem_12300", 32'(mem_model[18'h12300]), 32'hFF);
    check_eq("erase_keep_1200", 32'(mem_model[18'h01200]), 32'hA5);
    check_eq("erase_ignored_prog", 32'(mem_model[18'h00010]), 32'h00);
    read_sr(rb);
    check_eq("sr_after_erase", 32'(rb), 32'h00);

    // BLOCK_ERASE cut short after 2 address bytes
    wren();
    we_cnt = 0;
    mon_en = 1'b1;
    cs_begin();
    send_byte(8'hDC);
    send_byte(8'h00); send_byte(8'h01);
    cs_end();
    repeat (50) @(negedge clk);
    check_eq("short_erase_we", 32'(we_cnt), 0);
    check_eq("short_erase_wip", 32'(wip), 0);
    read_sr(rb);
    check_eq("short_erase_sr", 32'(rb), 32'h02);

    // Reset pulse in the middle of an erase walk
    cs_begin();
    send_byte(8'hDC);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    #(HALF);
    f_ncs = 1'b1;
    wait_wip(1'b1, 20, ok);
    check_eq("rst_erase_start", 32'(ok), 1);
    repeat (20) @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    check_eq("rst_erase_wip", 32'(wip), 0);
    check_eq("rst_erase_we", 32'(mem_we), 0);
    #20 nReset = 1'b1;
    we_cnt = 0;
    repeat (20) @(negedge clk);
    check_eq("rst_erase_abandoned", 32'(we_cnt), 0);
    mon_en = 1'b0;
    read_sr(rb);
    check_eq("sr_after_reset", 32'(rb), 32'h00);

    check_eq("we_re_exclusive", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
